// File: rtl/config_manager_uc_pkg.sv
// Shared definitions for the configuration control unit: header mark,
// FSM state encodings and limit-register index constants.
package config_manager_uc_pkg;

  localparam logic [7:0] HDR_MARK_DEF = 8'hA5;

  localparam logic [2:0] IDX_TEMP1 = 3'd0;
  localparam logic [2:0] IDX_TEMP2 = 3'd1;
  localparam logic [2:0] IDX_TEMP3 = 3'd2;
  localparam logic [2:0] IDX_TEMP4 = 3'd3;
  localparam logic [2:0] IDX_TEMP5 = 3'd4;
  localparam logic [2:0] IDX_TEMP6 = 3'd5;
  localparam logic [2:0] IDX_TEMP7 = 3'd6;
  localparam logic [2:0] IDX_UMID  = 3'd7;

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    ESPERA_CAB  = 4'd1,
    DECODIFICA  = 4'd2,
    ESPERA_DADO = 4'd3,
    CARREGA     = 4'd4,
    CONFIRMA    = 4'd5,
    ERRO        = 4'd6
  } estado_t;

  function automatic logic [7:0] idx_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/config_manager_uc_contador_m.sv
// Modulo-M up counter with synchronous clear (zera), enable (conta) and
// terminal-count flag (fim); used as the header-to-data timeout timer.
module contador_m #(
  parameter int unsigned M = 50_000_000
) (
  input  logic clock,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    cnt_q <= cnt_d;
  end

  assign fim = (cnt_q == LAST);

endmodule

// File: rtl/config_manager_uc.sv
// Control unit for the configuration datapath: receives header/data word
// pairs, strobes the selected limit register and tracks configured limits.
module config_manager_uc
  import config_manager_uc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0]  HDR_MARK       = HDR_MARK_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_config,
  input  logic        fim_recepcao_config,
  input  logic        parity_config_ok,
  input  logic [15:0] data_config,
  output logic        load_temp1,
  output logic        load_temp2,
  output logic        load_temp3,
  output logic        load_temp4,
  output logic        load_temp5,
  output logic        load_temp6,
  output logic        load_temp7,
  output logic        load_lim_um,
  output logic        config_ok,
  output logic        config_erro,
  output logic [7:0]  configurado,
  output logic        todos_configurados,
  output logic [3:0]  db_estado
);

  estado_t     state_q, state_d;
  logic [15:0] hdr_q, hdr_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [7:0]  load_q, load_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        tmr_fim;

  contador_m #(.M(TIMEOUT_CYCLES)) u_timer (
    .clock (clock),
    .zera  (reset || (state_q == DECODIFICA)),
    .conta (state_q == ESPERA_DADO),
    .fim   (tmr_fim)
  );

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cfg_d   = cfg_q;

    // The strobe fires for the whole CARREGA cycle, so the bit is recorded
    // even if enable_config drops in that same cycle.
    if (state_q == CARREGA) begin
      cfg_d = cfg_q | idx_onehot(hdr_q[2:0]);
    end

    if (!enable_config && (state_q != OCIOSO)) begin
      state_d = OCIOSO;
    end else begin
      unique case (state_q)
        OCIOSO:      if (enable_config) state_d = ESPERA_CAB;
        ESPERA_CAB: begin
          if (fim_recepcao_config) begin
            if (!parity_config_ok) begin
              state_d = ERRO;
            end else begin
              hdr_d   = data_config;
              state_d = DECODIFICA;
            end
          end
        end
        DECODIFICA: begin
          if ((hdr_q[15:8] == HDR_MARK) && (hdr_q[7:3] == 5'd0)) state_d = ESPERA_DADO;
          else state_d = ERRO;
        end
        ESPERA_DADO: begin
          if (fim_recepcao_config) state_d = parity_config_ok ? CARREGA : ERRO;
          else if (tmr_fim)        state_d = ERRO;
        end
        CARREGA:  state_d = CONFIRMA;
        CONFIRMA: state_d = ESPERA_CAB;
        ERRO:     state_d = ESPERA_CAB;
        default:  state_d = OCIOSO;
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    load_d = (state_d == CARREGA) ? idx_onehot(hdr_d[2:0]) : '0;
    ok_d   = (state_d == CONFIRMA);
    err_d  = (state_d == ERRO);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      load_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_q <= '0;
      cfg_q <= '0;
    end else begin
      hdr_q <= hdr_d;
      cfg_q <= cfg_d;
    end
  end

  assign load_temp1         = load_q[IDX_TEMP1];
  assign load_temp2         = load_q[IDX_TEMP2];
  assign load_temp3         = load_q[IDX_TEMP3];
  assign load_temp4         = load_q[IDX_TEMP4];
  assign load_temp5         = load_q[IDX_TEMP5];
  assign load_temp6         = load_q[IDX_TEMP6];
  assign load_temp7         = load_q[IDX_TEMP7];
  assign load_lim_um        = load_q[IDX_UMID];
  assign config_ok          = ok_q;
  assign config_erro        = err_q;
  assign configurado        = cfg_q;
  assign todos_configurados = &cfg_q;
  assign db_estado          = state_q;

endmodule

// File: tb/tb_config_manager_uc.sv
// Directed bench for config_manager_uc: vector table for the main frame
// flows plus hand-written timeout, abort and reset sequences.
module tb_config_manager_uc;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_config;
  logic        fim_recepcao_config;
  logic        parity_config_ok;
  logic [15:0] data_config;
  logic        load_temp1, load_temp2, load_temp3, load_temp4;
  logic        load_temp5, load_temp6, load_temp7, load_lim_um;
  logic        config_ok, config_erro, todos_configurados;
  logic [7:0]  configurado;
  logic [3:0]  db_estado;
  logic [7:0]  ld;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  exp_cfg;

  always #5 clock = ~clock;

  config_manager_uc #(.TIMEOUT_CYCLES(20), .HDR_MARK(8'hA5)) dut (
    .clock               (clock),
    .reset               (reset),
    .enable_config       (enable_config),
    .fim_recepcao_config (fim_recepcao_config),
    .parity_config_ok    (parity_config_ok),
    .data_config         (data_config),
    .load_temp1          (load_temp1),
    .load_temp2          (load_temp2),
    .load_temp3          (load_temp3),
    .load_temp4          (load_temp4),
    .load_temp5          (load_temp5),
    .load_temp6          (load_temp6),
    .load_temp7          (load_temp7),
    .load_lim_um         (load_lim_um),
    .config_ok           (config_ok),
    .config_erro         (config_erro),
    .configurado         (configurado),
    .todos_configurados  (todos_configurados),
    .db_estado           (db_estado)
  );

  assign ld = {load_lim_um, load_temp7, load_temp6, load_temp5,
               load_temp4, load_temp3, load_temp2, load_temp1};

  typedef struct {
    logic        en, pr, par;
    logic [15:0] data;
    logic [7:0]  ld;
    logic        ok, err;
    logic [7:0]  cfg;
    logic [3:0]  st;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic en, input logic pr, input logic par,
                              input logic [15:0] data, input logic [7:0] eld,
                              input logic eok, input logic eerr,
                              input logic [7:0] ecfg, input logic [3:0] est);
    vec_t v;
    v.en = en; v.pr = pr; v.par = par; v.data = data;
    v.ld = eld; v.ok = eok; v.err = eerr; v.cfg = ecfg; v.st = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eld, input logic eok,
                           input logic eerr, input logic [7:0] ecfg, input logic [3:0] est);
    chk({tag, " state"}, {12'd0, db_estado}, {12'd0, est});
    chk({tag, " load"}, {8'd0, ld}, {8'd0, eld});
    chk({tag, " ok"}, {15'd0, config_ok}, {15'd0, eok});
    chk({tag, " erro"}, {15'd0, config_erro}, {15'd0, eerr});
    chk({tag, " cfg"}, {8'd0, configurado}, {8'd0, ecfg});
    chk({tag, " todos"}, {15'd0, todos_configurados}, {15'd0, &ecfg});
  endtask

  task automatic drive(input logic en, input logic pr, input logic par, input logic [15:0] d);
    enable_config = en; fim_recepcao_config = pr; parity_config_ok = par; data_config = d;
    @(posedge clock);
    #1;
    fim_recepcao_config = 1'b0;
  endtask

  task automatic frame(input logic [2:0] idx, input logic [15:0] d);
    logic [7:0] oh;
    oh = 8'b1 << idx;
    drive(1'b1, 1'b1, 1'b1, {13'h14A0, idx});
    check_all($sformatf("frm%0d hdr", idx), 8'h00, 1'b0, 1'b0, exp_cfg, 4'd2);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all($sformatf("frm%0d dec", idx), 8'h00, 1'b0, 1'b0, exp_cfg, 4'd3);
    drive(1'b1, 1'b1, 1'b1, d);
    check_all($sformatf("frm%0d load", idx), oh, 1'b0, 1'b0, exp_cfg, 4'd4);
    exp_cfg = exp_cfg | oh;
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all($sformatf("frm%0d ok", idx), 8'h00, 1'b1, 1'b0, exp_cfg, 4'd5);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all($sformatf("frm%0d back", idx), 8'h00, 1'b0, 1'b0, exp_cfg, 4'd1);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h00, 4'd1);
    tbl[1]  = mk(1, 1, 1, 16'hA503, 8'h00, 0, 0, 8'h00, 4'd2);
    tbl[2]  = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h00, 4'd3);
    tbl[3]  = mk(1, 1, 1, 16'h0190, 8'h08, 0, 0, 8'h00, 4'd4);
    tbl[4]  = mk(1, 0, 1, 16'h0000, 8'h00, 1, 0, 8'h08, 4'd5);
    tbl[5]  = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h08, 4'd1);
    tbl[6]  = mk(1, 1, 1, 16'hA507, 8'h00, 0, 0, 8'h08, 4'd2);
    tbl[7]  = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h08, 4'd3);
    tbl[8]  = mk(1, 1, 1, 16'h0320, 8'h80, 0, 0, 8'h08, 4'd4);
    tbl[9]  = mk(1, 0, 1, 16'h0000, 8'h00, 1, 0, 8'h88, 4'd5);
    tbl[10] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h88, 4'd1);
    tbl[11] = mk(1, 1, 1, 16'hB203, 8'h00, 0, 0, 8'h88, 4'd2);
    tbl[12] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 1, 8'h88, 4'd6);
    tbl[13] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h88, 4'd1);
    tbl[14] = mk(1, 1, 1, 16'hA501, 8'h00, 0, 0, 8'h88, 4'd2);
    tbl[15] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h88, 4'd3);
    tbl[16] = mk(1, 1, 0, 16'h1234, 8'h00, 0, 1, 8'h88, 4'd6);
    tbl[17] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h88, 4'd1);
    tbl[18] = mk(1, 1, 0, 16'hA502, 8'h00, 0, 1, 8'h88, 4'd6);
    tbl[19] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h88, 4'd1);
    tbl[20] = mk(1, 1, 1, 16'hA50B, 8'h00, 0, 0, 8'h88, 4'd2);
    tbl[21] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 1, 8'h88, 4'd6);
    tbl[22] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h88, 4'd1);
    tbl[23] = mk(1, 1, 1, 16'hA500, 8'h00, 0, 0, 8'h88, 4'd2);
    tbl[24] = mk(1, 1, 1, 16'hA506, 8'h00, 0, 0, 8'h88, 4'd3);
    tbl[25] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h88, 4'd3);
    tbl[26] = mk(1, 1, 1, 16'h0042, 8'h01, 0, 0, 8'h88, 4'd4);
    tbl[27] = mk(1, 0, 1, 16'h0000, 8'h00, 1, 0, 8'h89, 4'd5);
    tbl[28] = mk(1, 0, 1, 16'h0000, 8'h00, 0, 0, 8'h89, 4'd1);

    reset = 1'b1; enable_config = 1'b1; fim_recepcao_config = 1'b1;
    parity_config_ok = 1'b1; data_config = 16'hA503;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_all("reset", 8'h00, 1'b0, 1'b0, 8'h00, 4'd0);
    reset = 1'b0;

    enable_config = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 16'hA503);
    check_all("idle", 8'h00, 1'b0, 1'b0, 8'h00, 4'd0);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].en, tbl[i].pr, tbl[i].par, tbl[i].data);
      check_all($sformatf("vec%0d", i), tbl[i].ld, tbl[i].ok, tbl[i].err, tbl[i].cfg, tbl[i].st);
    end
    exp_cfg = 8'h89;

    // Timeout: 20 cycles in ESPERA_DADO without data.
    drive(1'b1, 1'b1, 1'b1, 16'hA502);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all("to enter", 8'h00, 1'b0, 1'b0, exp_cfg, 4'd3);
    for (int c = 1; c < 20; c++) begin
      drive(1'b1, 1'b0, 1'b1, 16'h0000);
      check_all($sformatf("to wait%0d", c), 8'h00, 1'b0, 1'b0, exp_cfg, 4'd3);
    end
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all("to expire", 8'h00, 1'b0, 1'b1, exp_cfg, 4'd6);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all("to back", 8'h00, 1'b0, 1'b0, exp_cfg, 4'd1);

    // Data on the last allowed cycle wins over the timeout.
    drive(1'b1, 1'b1, 1'b1, 16'hA502);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    for (int c = 1; c < 20; c++) drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all("edge wait", 8'h00, 1'b0, 1'b0, exp_cfg, 4'd3);
    drive(1'b1, 1'b1, 1'b1, 16'h0155);
    check_all("edge load", 8'h04, 1'b0, 1'b0, exp_cfg, 4'd4);
    exp_cfg = exp_cfg | 8'h04;
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all("edge ok", 8'h00, 1'b1, 1'b0, exp_cfg, 4'd5);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);

    frame(3'd1, 16'h0111);
    frame(3'd4, 16'h0444);
    frame(3'd5, 16'h0555);
    frame(3'd6, 16'h0666);
    frame(3'd3, 16'h0333);

    // Abort while waiting for data.
    drive(1'b1, 1'b1, 1'b1, 16'hA501);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    check_all("abort pre", 8'h00, 1'b0, 1'b0, exp_cfg, 4'd3);
    drive(1'b0, 1'b1, 1'b1, 16'h0099);
    check_all("abort", 8'h00, 1'b0, 1'b0, exp_cfg, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    check_all("abort hold", 8'h00, 1'b0, 1'b0, exp_cfg, 4'd0);

    // Reset in the middle of a frame.
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    drive(1'b1, 1'b1, 1'b1, 16'hA504);
    check_all("rst pre", 8'h00, 1'b0, 1'b0, exp_cfg, 4'd2);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    reset = 1'b0;
    exp_cfg = 8'h00;
    check_all("rst mid", 8'h00, 1'b0, 1'b0, exp_cfg, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
